// File: rtl/cpi_read_ctrl_if.sv
// Bundle between the CSI-2 payload FIFO / frame configuration and the CPI
// read sequencer. The slave modport is the sequencer's view.
interface cpi_read_ctrl_if #(
    parameter int CNT_WIDTH = 12
);
    logic                 frame_start_i;
    logic [CNT_WIDTH-1:0] line_pixels_i;
    logic [CNT_WIDTH-1:0] frame_lines_i;
    logic [CNT_WIDTH-1:0] h_blank_i;
    logic                 fifo_empty_i;
    logic                 fifo_almost_empty_i;
    logic                 rd_en_o;
    logic                 vsync_o;
    logic                 hsync_o;
    logic                 pix_valid_o;
    logic                 underrun_o;
    logic                 frame_done_o;
    logic                 frame_abort_o;

    modport slave (
        input  frame_start_i, line_pixels_i, frame_lines_i, h_blank_i,
        input  fifo_empty_i, fifo_almost_empty_i,
        output rd_en_o, vsync_o, hsync_o, pix_valid_o,
        output underrun_o, frame_done_o, frame_abort_o
    );

    modport master (
        output frame_start_i, line_pixels_i, frame_lines_i, h_blank_i,
        output fifo_empty_i, fifo_almost_empty_i,
        input  rd_en_o, vsync_o, hsync_o, pix_valid_o,
        input  underrun_o, frame_done_o, frame_abort_o
    );
endinterface

// File: rtl/cpi_read_ctrl.sv
// Pixel-clock read sequencer: drains the payload FIFO one line at a time and
// produces CPI vsync/hsync framing with horizontal blanking and underrun flag.
module cpi_read_ctrl #(
    parameter int CNT_WIDTH = 12,
    parameter int VS_CYCLES = 16
) (
    input  logic           pixel_clk_i,
    input  logic           pixel_rst_i,
    cpi_read_ctrl_if.slave bus
);
    localparam int VS_W = (VS_CYCLES > 1) ? $clog2(VS_CYCLES) : 1;
    localparam logic [VS_W-1:0] VS_LAST = VS_W'(VS_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_WAIT_LINE,
        S_ACTIVE,
        S_HBLANK
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_line_pixels;
    logic [CNT_WIDTH-1:0] r_frame_lines;
    logic [CNT_WIDTH-1:0] r_h_blank;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_line_cnt;
    logic [CNT_WIDTH-1:0] w_line_inc;
    logic [VS_W-1:0]      r_vs_cnt;
    logic                 r_vsync;
    logic                 r_hsync;
    logic                 r_pix_valid;
    logic                 r_underrun;
    logic                 r_frame_done;
    logic                 r_frame_abort;
    logic                 w_start_ok;
    logic                 w_rd_en;
    logic                 w_line_end;
    logic                 w_last_line;
    logic                 w_frame_done;

    assign w_start_ok  = bus.frame_start_i && (bus.line_pixels_i != '0) &&
                         (bus.frame_lines_i != '0);
    assign w_rd_en     = (r_state == S_ACTIVE) && !bus.fifo_empty_i;
    assign w_line_inc  = r_line_cnt + 1'b1;
    assign w_last_line = (w_line_inc == r_frame_lines);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_line_end   = 1'b0;
        case (r_state)
            S_VSYNC: begin
                if (r_vs_cnt == VS_LAST) w_next_state = S_WAIT_LINE;
            end
            S_WAIT_LINE: begin
                if (!bus.fifo_almost_empty_i) w_next_state = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (r_cnt == r_line_pixels - 1'b1) begin
                    if (r_h_blank == '0) begin
                        w_line_end   = 1'b1;
                        w_next_state = w_last_line ? S_IDLE : S_WAIT_LINE;
                    end else begin
                        w_next_state = S_HBLANK;
                    end
                end
            end
            S_HBLANK: begin
                if (r_cnt == r_h_blank - 1'b1) begin
                    w_line_end   = 1'b1;
                    w_next_state = w_last_line ? S_IDLE : S_WAIT_LINE;
                end
            end
            default: w_next_state = r_state;
        endcase
        // A valid frame start overrides every other transition, including mid-frame.
        if (w_start_ok) w_next_state = S_VSYNC;
    end

    assign w_frame_done = w_line_end && w_last_line && !w_start_ok;

    always_ff @(posedge pixel_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (pixel_rst_i) begin
            r_state       <= S_IDLE;
            r_line_pixels <= '0;
            r_frame_lines <= '0;
            r_h_blank     <= '0;
            r_cnt         <= '0;
            r_line_cnt    <= '0;
            r_vs_cnt      <= '0;
            r_vsync       <= 1'b0;
            r_hsync       <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_vsync       <= (w_next_state == S_VSYNC);
            r_hsync       <= (r_state == S_ACTIVE);
            r_pix_valid   <= w_rd_en;
            r_frame_done  <= w_frame_done;
            r_frame_abort <= w_start_ok && (r_state != S_IDLE);
            if (w_start_ok) begin
                r_line_pixels <= bus.line_pixels_i;
                r_frame_lines <= bus.frame_lines_i;
                r_h_blank     <= bus.h_blank_i;
                r_cnt         <= '0;
                r_line_cnt    <= '0;
                r_vs_cnt      <= '0;
                r_underrun    <= 1'b0;
            end else begin
                if ((r_state == S_ACTIVE) && bus.fifo_empty_i) r_underrun <= 1'b1;
                if (w_next_state != r_state) begin
                    r_cnt <= '0;
                end else if ((r_state == S_ACTIVE) || (r_state == S_HBLANK)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_vs_cnt <= ((r_state == S_VSYNC) && (w_next_state == S_VSYNC)) ?
                            r_vs_cnt + 1'b1 : '0;
                if (w_line_end) r_line_cnt <= w_line_inc;
            end
        end
    end

    assign bus.rd_en_o       = w_rd_en;
    assign bus.vsync_o       = r_vsync;
    assign bus.hsync_o       = r_hsync;
    assign bus.pix_valid_o   = r_pix_valid;
    assign bus.underrun_o    = r_underrun;
    assign bus.frame_done_o  = r_frame_done;
    assign bus.frame_abort_o = r_frame_abort;
endmodule

// File: tb/tb_cpi_read_ctrl.sv
// Directed bench for cpi_read_ctrl: per-cycle output traces are recorded and
// compared against hand-computed cycle positions for each scenario.
module tb_cpi_read_ctrl;
    localparam int CW = 12;
    localparam int B_RD = 0, B_VS = 1, B_HS = 2, B_PV = 3, B_UR = 4, B_FD = 5, B_FA = 6;

    logic pixel_clk_i;
    logic pixel_rst_i;
    int   vectors;
    int   miscompares;
    logic [6:0] rec [0:127];

    cpi_read_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    cpi_read_ctrl #(.CNT_WIDTH(CW), .VS_CYCLES(16)) dut (
        .pixel_clk_i (pixel_clk_i),
        .pixel_rst_i (pixel_rst_i),
        .bus         (bus)
    );

    initial pixel_clk_i = 1'b0;
    always #5 pixel_clk_i = ~pixel_clk_i;

    task automatic sample(input int k);
        #1;
        rec[k] = {bus.frame_abort_o, bus.frame_done_o, bus.underrun_o, bus.pix_valid_o,
                  bus.hsync_o, bus.vsync_o, bus.rd_en_o};
    endtask

    function automatic int cnt(input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(rec[i][b]);
        return n;
    endfunction

    function automatic int first(input int b, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (rec[i][b] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int busy(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (rec[i] !== 7'd0) n++;
        return n;
    endfunction

    task automatic idle_inputs();
        bus.frame_start_i       = 1'b0;
        bus.line_pixels_i       = '0;
        bus.frame_lines_i       = '0;
        bus.h_blank_i           = '0;
        bus.fifo_empty_i        = 1'b0;
        bus.fifo_almost_empty_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge pixel_clk_i); #1;
        pixel_rst_i = 1'b1;
        idle_inputs();
        @(posedge pixel_clk_i); #1;
        pixel_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        for (int k = 0; k < 8; k++) begin
            @(posedge pixel_clk_i); #1;
            pixel_rst_i         = (k < 4);
            bus.frame_start_i   = 1'b1;
            bus.line_pixels_i   = 12'd4;
            bus.frame_lines_i   = 12'd2;
            if (k >= 4) bus.frame_start_i = 1'b0;
            sample(k);
        end
        vectors++;
        n = busy(1, 7);
        if (n !== 0) begin
            miscompares++;
            $display("FAIL reset_outputs_zero: got %0d nonzero cycles, expected 0", n);
        end
    endtask

    task automatic test_nominal();
        int v;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            @(posedge pixel_clk_i); #1;
            bus.frame_start_i = (k == 0);
            bus.line_pixels_i = 12'd4;
            bus.frame_lines_i = 12'd2;
            bus.h_blank_i     = 12'd3;
            sample(k);
        end
        vectors++; v = cnt(B_VS, 0, 39);
        if (v !== 16) begin miscompares++; $display("FAIL nom_vsync_len: got %0d expected 16", v); end
        vectors++; v = first(B_VS, 0, 39);
        if (v !== 1) begin miscompares++; $display("FAIL nom_vsync_rise: got %0d expected 1", v); end
        vectors++; v = first(B_RD, 0, 39);
        if (v !== 18) begin miscompares++; $display("FAIL nom_first_rd: got %0d expected 18", v); end
        vectors++; v = first(B_HS, 0, 39);
        if (v !== 19) begin miscompares++; $display("FAIL nom_first_hsync: got %0d expected 19", v); end
        vectors++; v = cnt(B_HS, 19, 22);
        if (v !== 4) begin miscompares++; $display("FAIL nom_line0_window: got %0d expected 4", v); end
        vectors++; v = first(B_HS, 23, 39);
        if (v !== 27) begin miscompares++; $display("FAIL nom_line1_start: got %0d expected 27", v); end
        vectors++; v = cnt(B_HS, 0, 39);
        if (v !== 8) begin miscompares++; $display("FAIL nom_hsync_total: got %0d expected 8", v); end
        vectors++; v = cnt(B_PV, 19, 22) + cnt(B_PV, 27, 30);
        if (v !== 8) begin miscompares++; $display("FAIL nom_pix_valid: got %0d expected 8", v); end
        vectors++; v = first(B_FD, 0, 39);
        if (v !== 33) begin miscompares++; $display("FAIL nom_frame_done_at: got %0d expected 33", v); end
        vectors++; v = cnt(B_FD, 0, 39);
        if (v !== 1) begin miscompares++; $display("FAIL nom_frame_done_cnt: got %0d expected 1", v); end
        vectors++; v = cnt(B_UR, 0, 39);
        if (v !== 0) begin miscompares++; $display("FAIL nom_underrun: got %0d expected 0", v); end
    endtask

    task automatic test_underrun();
        int v;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            @(posedge pixel_clk_i); #1;
            bus.frame_start_i = (k == 0) || (k == 35);
            bus.line_pixels_i = 12'd8;
            bus.frame_lines_i = 12'd1;
            bus.h_blank_i     = 12'd2;
            bus.fifo_empty_i  = (k == 21);
            sample(k);
        end
        vectors++;
        if (rec[21][B_RD] !== 1'b0 || rec[20][B_RD] !== 1'b1) begin
            miscompares++;
            $display("FAIL ur_rd_gap: got rd[20]=%b rd[21]=%b expected 1 0", rec[20][B_RD], rec[21][B_RD]);
        end
        vectors++; v = cnt(B_RD, 0, 39);
        if (v !== 7) begin miscompares++; $display("FAIL ur_rd_count: got %0d expected 7", v); end
        vectors++;
        if (rec[22][B_PV] !== 1'b0 || rec[21][B_PV] !== 1'b1) begin
            miscompares++;
            $display("FAIL ur_pix_valid_gap: got pv[21]=%b pv[22]=%b expected 1 0", rec[21][B_PV], rec[22][B_PV]);
        end
        vectors++; v = cnt(B_HS, 19, 26);
        if (v !== 8) begin miscompares++; $display("FAIL ur_hsync_window: got %0d expected 8", v); end
        vectors++; v = first(B_UR, 0, 39);
        if (v !== 22) begin miscompares++; $display("FAIL ur_set_at: got %0d expected 22", v); end
        vectors++; v = cnt(B_UR, 22, 35);
        if (v !== 14) begin miscompares++; $display("FAIL ur_sticky: got %0d expected 14", v); end
        vectors++;
        if (rec[36][B_UR] !== 1'b0) begin
            miscompares++;
            $display("FAIL ur_clear_on_start: got %b expected 0", rec[36][B_UR]);
        end
    endtask

    task automatic test_line_gating();
        int v;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            @(posedge pixel_clk_i); #1;
            bus.frame_start_i       = (k == 0);
            bus.line_pixels_i       = 12'd4;
            bus.frame_lines_i       = 12'd1;
            bus.h_blank_i           = 12'd0;
            bus.fifo_empty_i        = 1'b0;
            bus.fifo_almost_empty_i = (k < 37);
            sample(k);
        end
        vectors++; v = cnt(B_RD, 0, 37) + cnt(B_HS, 0, 38);
        if (v !== 0) begin miscompares++; $display("FAIL gate_hold_quiet: got %0d expected 0", v); end
        vectors++; v = first(B_RD, 0, 49);
        if (v !== 38) begin miscompares++; $display("FAIL gate_active_start: got %0d expected 38", v); end
        vectors++; v = cnt(B_HS, 0, 49);
        if (v !== 4) begin miscompares++; $display("FAIL gate_hsync_len: got %0d expected 4", v); end
        vectors++; v = first(B_FD, 0, 49);
        if (v !== 42) begin miscompares++; $display("FAIL gate_frame_done: got %0d expected 42", v); end
    endtask

    task automatic test_abort();
        int v;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            @(posedge pixel_clk_i); #1;
            bus.frame_start_i = (k == 0) || (k == 20);
            bus.line_pixels_i = (k == 0) ? 12'd8 : ((k == 20) ? 12'd3 : 12'd9);
            bus.frame_lines_i = (k == 0) ? 12'd2 : ((k == 20) ? 12'd1 : 12'd5);
            bus.h_blank_i     = (k == 0) ? 12'd2 : ((k == 20) ? 12'd1 : 12'd7);
            sample(k);
        end
        vectors++; v = first(B_FA, 0, 59);
        if (v !== 21) begin miscompares++; $display("FAIL abort_pulse_at: got %0d expected 21", v); end
        vectors++; v = cnt(B_FA, 0, 59);
        if (v !== 1) begin miscompares++; $display("FAIL abort_pulse_cnt: got %0d expected 1", v); end
        vectors++;
        if (rec[20][B_RD] !== 1'b1 || rec[21][B_RD] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_rd_drop: got rd[20]=%b rd[21]=%b expected 1 0", rec[20][B_RD], rec[21][B_RD]);
        end
        vectors++; v = cnt(B_VS, 21, 59);
        if (v !== 16 || rec[21][B_VS] !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_vsync_restart: got %0d cycles expected 16", v);
        end
        vectors++; v = cnt(B_HS, 30, 59);
        if (v !== 3 || first(B_HS, 30, 59) !== 39) begin
            miscompares++;
            $display("FAIL abort_new_line_len: got %0d cycles expected 3 from 39", v);
        end
        vectors++; v = first(B_FD, 0, 59);
        if (v !== 42 || cnt(B_FD, 0, 59) !== 1) begin
            miscompares++;
            $display("FAIL abort_frame_done: got first at %0d expected 42", v);
        end
    endtask

    task automatic test_zero_and_hblank0();
        int v;
        logic [7:0] hs_pat;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            @(posedge pixel_clk_i); #1;
            bus.frame_start_i = (k == 0);
            bus.line_pixels_i = 12'd4;
            bus.frame_lines_i = 12'd0;
            bus.h_blank_i     = 12'd3;
            sample(k);
        end
        vectors++; v = busy(0, 24);
        if (v !== 0) begin miscompares++; $display("FAIL zero_cfg_ignored: got %0d busy cycles expected 0", v); end
        for (int k = 0; k < 35; k++) begin
            @(posedge pixel_clk_i); #1;
            bus.frame_start_i = (k == 0);
            bus.line_pixels_i = 12'd2;
            bus.frame_lines_i = 12'd3;
            bus.h_blank_i     = 12'd0;
            sample(k);
        end
        for (int i = 0; i < 8; i++) hs_pat[7-i] = rec[19+i][B_HS];
        vectors++;
        if (hs_pat !== 8'b1101_1011) begin
            miscompares++;
            $display("FAIL hb0_hsync_pattern: got %b expected 11011011", hs_pat);
        end
        vectors++; v = cnt(B_HS, 0, 34);
        if (v !== 6) begin miscompares++; $display("FAIL hb0_hsync_total: got %0d expected 6", v); end
        vectors++; v = first(B_FD, 0, 34);
        if (v !== 26) begin miscompares++; $display("FAIL hb0_frame_done: got %0d expected 26", v); end
    endtask

    task automatic test_reset_mid_active();
        int v;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            @(posedge pixel_clk_i); #1;
            pixel_rst_i       = (k == 20);
            bus.frame_start_i = (k == 0);
            bus.line_pixels_i = 12'd8;
            bus.frame_lines_i = 12'd1;
            bus.h_blank_i     = 12'd0;
            sample(k);
        end
        vectors++;
        if (rec[20][B_RD] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_was_active: got %b expected 1", rec[20][B_RD]);
        end
        vectors++;
        if (rec[21] !== 7'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %b expected 0000000", rec[21]);
        end
        vectors++; v = busy(21, 49);
        if (v !== 0) begin miscompares++; $display("FAIL rst_mid_stays_idle: got %0d busy cycles expected 0", v); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pixel_rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_nominal();
        test_underrun();
        test_line_gating();
        test_abort();
        test_zero_and_hblank0();
        test_reset_mid_active();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpi_read_ctrl.md
# cpi_read_ctrl

Pixel-clock-domain read sequencer for the CSI-2 payload FIFO. It turns the unpacked payload stream into CPI-style frame timing. It drives the FIFO read enable one line at a time and generates the `vsync_o`/`hsync_o` framing with blanking. It also flags FIFO underruns. It sits between the payload FIFO read port and the parallel CPI output.

## Interface
- `CNT_WIDTH`, 12: width of the pixel, line and blanking counters and their config inputs.
- `VS_CYCLES`, 16: number of cycles `vsync_o` is held high at frame start (≥1).

- `pixel_clk_i`  in  1  pixel clock; the only clock.
- `pixel_rst_i`  in  1  synchronous, active-high reset.
- `frame_start_i`  in  1  single-cycle pulse; a new frame's payload has started arriving (already synchronised to `pixel_clk_i`).
- `line_pixels_i`  in  CNT_WIDTH  pixels (FIFO words) per line; sampled at frame start.
- `frame_lines_i`  in  CNT_WIDTH  lines per frame; sampled at frame start.
- `h_blank_i`  in  CNT_WIDTH  horizontal blanking cycles after each line; sampled at frame start; 0 is allowed.
- `fifo_empty_i`  in  1  payload FIFO empty.
- `fifo_almost_empty_i`  in  1  payload FIFO below its almost-empty threshold.
- `rd_en_o`  out  1  payload FIFO read enable.
- `vsync_o`  out  1  CPI frame sync.
- `hsync_o`  out  1  CPI line valid, aligned with FIFO read data.
- `pix_valid_o`  out  1  the current FIFO `rd_data_o` word is a real pixel.
- `underrun_o`  out  1  sticky; a read was needed while the FIFO was empty during this frame.
- `frame_done_o`  out  1  single-cycle pulse after the last line's blanking completes.
- `frame_abort_o`  out  1  single-cycle pulse when `frame_start_i` arrives mid-frame.

## Operation
- FSM states: IDLE, VSYNC, WAIT_LINE, ACTIVE, HBLANK. State is registered and resets to IDLE.
- **IDLE:**
  - On `frame_start_i` with `line_pixels_i`≠0 and `frame_lines_i`≠0: latch all three config values, clear `underrun_o`, clear the counters, go to VSYNC.
  - If either config value is zero, `frame_start_i` is ignored and the block stays in IDLE.
- **VSYNC:** stay `VS_CYCLES` cycles, then go to WAIT_LINE.
- **WAIT_LINE:** go to ACTIVE on the first cycle with `fifo_almost_empty_i`=0.
- **ACTIVE:**
  - Runs exactly the latched `line_pixels` cycles, with the pixel counter advancing every cycle.
  - `rd_en_o` = ACTIVE & ~`fifo_empty_i`.
  - An ACTIVE cycle with `fifo_empty_i`=1 sets `underrun_o`. No read is issued, and the line still ends on schedule, so CPI timing is preserved.
  - After the last pixel, go to HBLANK, or skip it if `h_blank`=0.
- **HBLANK:** stay `h_blank` cycles, then increment the line counter.
  - If lines done = `frame_lines`: pulse `frame_done_o` and go to IDLE.
  - Otherwise go to WAIT_LINE.
  - When `h_blank`=0, these end-of-line actions happen on leaving ACTIVE.
- **Mid-frame restart:** `frame_start_i` in any non-IDLE state, with valid config, pulses `frame_abort_o`, relatches config, clears the counters and `underrun_o`, and goes to VSYNC. It has priority over all other transitions.
- Counters are CNT_WIDTH wide and compare against latched config by equality; they never wrap within a legal frame.
- **Reset mid-frame:** return to IDLE next cycle with all outputs at their reset values. FIFO contents are not this block's concern.

## Timing
- **Reset values:** every output is 0.
- **Registered outputs:** `vsync_o` is 1 exactly while the state is VSYNC. It rises the cycle after `frame_start_i` and is high for `VS_CYCLES` cycles.
- **Combinational output:** `rd_en_o` is combinational from the state register and `fifo_empty_i`, for same-cycle FIFO read.
- **Read-data alignment:** the FIFO read latency is 1 cycle. Therefore:
  - `pix_valid_o` is `rd_en_o` delayed by 1.
  - `hsync_o` is (state==ACTIVE) delayed by 1.
  - Each `hsync_o` window is exactly `line_pixels` cycles.
- **WAIT_LINE → ACTIVE:** if `fifo_almost_empty_i`=0 in WAIT_LINE at cycle T, ACTIVE starts at T+1, `rd_en_o` can first be high at T+1, and `hsync_o` first rises at T+2.
- **Blanking gap:** between lines, `hsync_o` is low for at least `h_blank`+1 cycles (HBLANK plus at least one WAIT_LINE cycle).
- **`frame_done_o`:** asserted in the cycle the FSM enters IDLE.
- **Event priority, simultaneous events:** reset, then `frame_start_i`, then normal transitions.

## Test plan
- **Nominal frame:** `line_pixels`=4, `frame_lines`=2, `h_blank`=3, `VS_CYCLES`=16, FIFO never empty → `vsync_o` high 16 cycles; two `hsync_o` windows of 4 cycles, each with `pix_valid_o`=1 throughout; ≥4 low cycles between them; one `frame_done_o`; `underrun_o`=0.
- **Underrun:** `line_pixels`=8, force `fifo_empty_i`=1 on pixel 3 → `rd_en_o` low for that cycle; `pix_valid_o` low one cycle later; `hsync_o` window still 8 cycles; `underrun_o` stays 1 until the next `frame_start_i`.
- **Line gating:** hold `fifo_almost_empty_i`=1 for 20 cycles after VSYNC → no `rd_en_o`/`hsync_o` during the hold; ACTIVE begins 1 cycle after the release.
- **Abort:** `frame_start_i` during line 1 ACTIVE → one-cycle `frame_abort_o`; `rd_en_o` drops next cycle; `vsync_o` restarts for 16 cycles; new config is used.
- **Zero config and `h_blank`=0:** `frame_lines_i`=0 → `frame_start_i` ignored, all outputs stay 0. `h_blank`=0, `line_pixels`=2, `frame_lines`=3 → `hsync_o` gaps are exactly 1 cycle.
- **Reset mid-ACTIVE:** assert `pixel_rst_i` one cycle → all outputs 0 the next cycle; `rd_en_o` stays 0 until a new `frame_start_i`.
